// File: rtl/wb_reg_file_if.sv
// Register-file bus: two decode read ports, the write-back write port, and the live special-register taps.
interface wb_reg_file_if #(
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned ADDR_W = 4;

  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] ih_data;
  logic [DATA_W-1:0] sp_data;
  logic [DATA_W-1:0] t_data;

  modport master (
    output rd_addr_a, rd_addr_b, wb_we, wb_addr, wb_data,
    input  rd_data_a, rd_data_b, ih_data, sp_data, t_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wb_we, wb_addr, wb_data,
    output rd_data_a, rd_data_b, ih_data, sp_data, t_data
  );
endinterface

// File: rtl/wb_reg_file.sv
// Architectural register file: R0-R7, SP, IH, RA, T behind one write port and two combinational read ports.
// Define WB_REG_FILE_BYPASS_EN to forward the in-flight write-back word onto matching read ports.
module wb_reg_file #(
  parameter int unsigned        DATA_W   = 16,
  parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(16'hBF00),
  parameter logic [DATA_W-1:0]  IH_RESET = DATA_W'(16'h0000)
) (
  input  logic           clk,
  input  logic           rst,
  wb_reg_file_if.slave   bus
);
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 12;
  localparam int unsigned IDX_SP   = 8;
  localparam int unsigned IDX_IH   = 9;
  localparam int unsigned IDX_T    = 11;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_en_c;
  logic [DATA_W-1:0] rd_data_a_c;
  logic [DATA_W-1:0] rd_data_b_c;

  // Indices 12-15 are legal no-op destinations (15 marks pipeline bubbles).
  assign wr_en_c = bus.wb_we && (bus.wb_addr < ADDR_W'(NUM_REGS));

  always_comb begin
    regs_d = regs_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_en_c && (bus.wb_addr == ADDR_W'(i))) begin
        regs_d[i] = bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[IDX_SP] <= SP_RESET;
      regs_q[IDX_IH] <= IH_RESET;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Unmapped indices read as zero.
  always_comb begin
    rd_data_a_c = '0;
    rd_data_b_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) rd_data_a_c = regs_q[i];
      if (bus.rd_addr_b == ADDR_W'(i)) rd_data_b_c = regs_q[i];
    end
`ifdef WB_REG_FILE_BYPASS_EN
    if (!rst && wr_en_c && (bus.rd_addr_a == bus.wb_addr)) rd_data_a_c = bus.wb_data;
    if (!rst && wr_en_c && (bus.rd_addr_b == bus.wb_addr)) rd_data_b_c = bus.wb_data;
`endif
  end

  assign bus.rd_data_a = rd_data_a_c;
  assign bus.rd_data_b = rd_data_b_c;

  // Special-register taps always show stored state, never the bypassed word.
  assign bus.ih_data = regs_q[IDX_IH];
  assign bus.sp_data = regs_q[IDX_SP];
  assign bus.t_data  = regs_q[IDX_T];

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Architectural register file at the end of the pipeline.
- Consumes the selected write-back word from the write-back data mux.
- Supplies two decode-stage read ports.
- Drives the live IH register value back to the write-back mux `wb_IH` input and the live SP value to the decode stage.
- Holds 8 general registers plus the special registers SP, IH, RA and T in one block, with a single write port and reset-defined contents.

Parameters:
- DATA_W, 16, width of every register and data port; matches `DATA_BUS`.
- SP_RESET, 16'hBF00, value loaded into SP on reset.
- IH_RESET, 16'h0000, value loaded into IH on reset.

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  asynchronous active-high reset.
- rd_addr_a  input  4  read port A register index.
- rd_addr_b  input  4  read port B register index.
- rd_data_a  output  DATA_W  read port A data.
- rd_data_b  output  DATA_W  read port B data.
- wb_we  input  1  write enable from the write-back stage.
- wb_addr  input  4  destination register index.
- wb_data  input  DATA_W  write data (output of the write-back data mux).
- ih_data  output  DATA_W  current IH register; feeds the write-back mux `wb_IH`.
- sp_data  output  DATA_W  current SP register.
- t_data  output  DATA_W  current T register (branch-on-T condition).

Behaviour:
- Index map:
  - 0-7 = R0-R7
  - 8 = SP
  - 9 = IH
  - 10 = RA
  - 11 = T
  - 12-14 = reserved
  - 15 = NONE (no destination / no source)
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - R0-R7, RA, T = 0.
  - SP = SP_RESET.
  - IH = IH_RESET.
  - While rst is high, no write occurs regardless of wb_we.
  - Deassertion is sampled normally; the first write is accepted on the first rising edge with rst=0.
- Write:
  - On a rising edge with wb_we=1 and wb_addr in 0-11, the register at wb_addr <= wb_data.
  - Exactly one register changes per cycle.
  - wb_addr in 12-15 with wb_we=1: no state change. This is legal, not an error; the pipeline uses 15 for bubbles.
  - wb_we=0: no state change, whatever wb_addr and wb_data are.
- Read:
  - Combinational, zero latency.
  - Index 0-11 returns the stored value; index 12-15 returns 0.
  - Ports A and B are fully independent; both may address the same register.
- ih_data, sp_data and t_data:
  - Always reflect stored register contents, never bypassed.
  - Update in the same cycle as the write edge (visible immediately after the edge).
  - After reset: ih_data=IH_RESET, sp_data=SP_RESET, t_data=0.
- Simultaneous read and write of the same register in one cycle: governed by the optional feature below.
- There is no hard-wired zero register; R0 is an ordinary writable register.
- All arithmetic is none. The block stores and forwards full DATA_W words without truncation or extension.

Optional Feature:
- Macro: WB_REG_FILE_BYPASS_EN.
- Defined:
  - Write-through bypass on both read ports.
  - If wb_we=1, wb_addr in 0-11 and rd_addr_x==wb_addr, then rd_data_x = wb_data in that same cycle (before the edge).
  - No bypass when rst=1 (reads return reset contents).
  - ih_data, sp_data and t_data are still unbypassed.
- Not defined:
  - Reads always return stored contents.
  - A value written at edge N is first visible on rd_data_x after edge N.
  - The hazard unit must then cover the extra cycle.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge. Required: rd_data_a (addr 8)=16'hBF00 immediately; rd_data_b (addr 9)=0; ih_data=0; t_data=0; R3=0.
- Basic write/read: wb_we=1, wb_addr=5, wb_data=16'h1234, one edge, then wb_we=0. Required: rd_addr_a=5 gives 16'h1234; other GPRs unchanged at 0.
- Special registers: write 9 <- 16'h00FF, 11 <- 16'h0001, 8 <- 16'hBEFF on consecutive edges. Required: after each edge, ih_data=16'h00FF, t_data=1, sp_data=16'hBEFF respectively.
- Reserved/NONE index: wb_we=1, wb_addr=15, wb_data=16'hFFFF, then addr 12 with the same data. Required: no register changes; reads of 12-15 return 0.
- Same-cycle read/write: R2=16'h0007 stored; drive wb_we=1, wb_addr=2, wb_data=16'hAAAA, rd_addr_a=rd_addr_b=2 before the edge. Required: rd_data_a=rd_data_b=16'hAAAA with WB_REG_FILE_BYPASS_EN, 16'h0007 without; both 16'hAAAA after the edge.
- Reset during write: wb_we=1, wb_addr=1, wb_data=16'h5555 with rst=1 across an edge, then release. Required: R1=0 after release; the next edge with wb_we=1 writes normally.
